trojan_resp_checker: RTL and testbench

Hardware reader for stimulus/response records produced around a DUT under trojan test. It accepts a stream of (stimulus bit, DUT response bit, expected response bit) records and compacts each (stimulus, response) pair into a MISR signature. It counts per-vector mismatches and, after a fixed run length, compares the signature with a golden value to raise a pass or trojan flag. It sits between the DUT harness and the result-logging path.

---
 rtl/trojan_chk_pkg.sv | 36 +++
 rtl/misr_compactor.sv | 41 ++++
 rtl/trojan_resp_checker.sv | 130 +++++++++++++
 tb/tb_trojan_resp_checker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trojan_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trojan_chk_pkg
// Purpose  : Shared types, default constants and MISR step function for the
//            trojan response checker.
// Revision : 1.0 - initial release
// ============================================================================
package trojan_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [15:0] c_DEF_POLY      = 16'h1021;
    localparam logic [15:0] c_DEF_MISR_SEED = 16'h0000;
    localparam int          c_MISR_W_MAX    = 64;

    // Works on a 64-bit container; width selects the live signature bits.
    function automatic logic [63:0] misr_step(
        input logic [63:0] sig,
        input logic [1:0]  data2,
        input logic [63:0] poly,
        input int unsigned width
    );
        logic [63:0] w_mask;
        logic [63:0] w_fb;
        w_mask = (64'd1 << width) - 64'd1;
        w_fb   = (((sig >> (width - 1)) & 64'd1) != 64'd0) ? poly : 64'd0;
        misr_step = (((sig << 1) ^ w_fb) & w_mask) ^ {62'd0, data2};
    endfunction

endpackage
`default_nettype wire

// File: rtl/misr_compactor.sv
`default_nettype none
// ============================================================================
// Module   : misr_compactor
// Purpose  : Signature register with seed load and per-record step enable.
// Revision : 1.0 - initial release
// ============================================================================
module misr_compactor
    import trojan_chk_pkg::*;
#(
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] POLY      = MISR_W'(c_DEF_POLY),
    parameter logic [MISR_W-1:0] MISR_SEED = MISR_W'(c_DEF_MISR_SEED)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [1:0]        i_data,
    output logic [MISR_W-1:0] o_sig
);

    logic [MISR_W-1:0] r_sig;
    logic [MISR_W-1:0] w_next;

    assign w_next = MISR_W'(misr_step(64'(r_sig), i_data, 64'(POLY), MISR_W));

    // Reset clears to zero; the seed only appears when a run is launched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= '0;
        end else if (i_load) begin
            r_sig <= MISR_SEED;
        end else if (i_step) begin
            r_sig <= w_next;
        end
    end

    assign o_sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/trojan_resp_checker.sv
`default_nettype none
// ============================================================================
// Module   : trojan_resp_checker
// Purpose  : Compacts stimulus/response records into a MISR, counts response
//            mismatches and flags pass/trojan against a golden signature.
// Revision : 1.0 - initial release
// ============================================================================
module trojan_resp_checker
    import trojan_chk_pkg::*;
#(
    parameter int                VEC_COUNT = 2,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] POLY      = MISR_W'(c_DEF_POLY),
    parameter logic [MISR_W-1:0] MISR_SEED = MISR_W'(c_DEF_MISR_SEED),
    parameter int                CNT_W     = $clog2(VEC_COUNT + 1)
)(
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              N,
    input  logic              resp,
    input  logic              exp_resp,
    input  logic [MISR_W-1:0] golden_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              trojan_flag,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [CNT_W-1:0]  first_mis_idx,
    output logic [MISR_W-1:0] signature
);

    localparam logic [1:0]       c_S_IDLE   = ST_IDLE;
    localparam logic [1:0]       c_S_RUN    = ST_RUN;
    localparam logic [1:0]       c_S_CHECK  = ST_CHECK;
    localparam logic [1:0]       c_S_DONE   = ST_DONE;
    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(VEC_COUNT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_vec_idx;
    logic [CNT_W-1:0] r_mis_cnt;
    logic [CNT_W-1:0] r_first_idx;
    logic             r_pass;
    logic             r_trojan;

    logic w_start_run;
    logic w_hs;
    logic w_last;
    logic w_mis;
    logic w_match;

    assign w_start_run = start && ((r_state == c_S_IDLE) || (r_state == c_S_DONE));
    assign w_hs        = in_valid && (r_state == c_S_RUN);
    assign w_last      = w_hs && (r_vec_idx == c_LAST_IDX);
    assign w_mis       = w_hs && (resp != exp_resp);
    assign w_match     = (signature == golden_sig) && (r_mis_cnt == '0);

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE, c_S_DONE: if (start) r_state <= c_S_RUN;
                c_S_RUN:            if (w_last) r_state <= c_S_CHECK;
                c_S_CHECK:          r_state <= c_S_DONE;
                default:            r_state <= c_S_IDLE;
            endcase
        end
    end

    // The first-mismatch index is latched only on the zero-to-one count step.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            r_vec_idx   <= '0;
            r_mis_cnt   <= '0;
            r_first_idx <= '0;
        end else if (w_start_run) begin
            r_vec_idx   <= '0;
            r_mis_cnt   <= '0;
            r_first_idx <= '0;
        end else if (w_hs) begin
            r_vec_idx <= r_vec_idx + c_CNT_ONE;
            if (w_mis) begin
                r_mis_cnt <= r_mis_cnt + c_CNT_ONE;
                if (r_mis_cnt == '0) begin
                    r_first_idx <= r_vec_idx;
                end
            end
        end
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            r_pass   <= 1'b0;
            r_trojan <= 1'b0;
        end else if (w_start_run) begin
            r_pass   <= 1'b0;
            r_trojan <= 1'b0;
        end else if (r_state == c_S_CHECK) begin
            r_pass   <= w_match;
            r_trojan <= ~w_match;
        end
    end

    misr_compactor #(
        .MISR_W    (MISR_W),
        .POLY      (POLY),
        .MISR_SEED (MISR_SEED)
    ) u_misr (
        .clk    (CK),
        .rst    (reset),
        .i_load (w_start_run),
        .i_step (w_hs),
        .i_data ({N, resp}),
        .o_sig  (signature)
    );

    assign in_ready      = (r_state == c_S_RUN);
    assign busy          = (r_state == c_S_RUN) || (r_state == c_S_CHECK);
    assign done          = (r_state == c_S_DONE);
    assign pass          = r_pass;
    assign trojan_flag   = r_trojan;
    assign mismatch_cnt  = r_mis_cnt;
    assign first_mis_idx = r_first_idx;

endmodule
`default_nettype wire

// File: tb/tb_trojan_resp_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_trojan_resp_checker
// Purpose  : Scoreboard bench for trojan_resp_checker (default and seeded).
// Revision : 1.0 - initial release
// ============================================================================
module tb_trojan_resp_checker;

    typedef struct {
        logic [15:0] sig;
        logic [1:0]  cnt;
        logic [1:0]  first;
        logic        pass;
    } exp_t;

    logic        CK = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        N = 1'b0;
    logic        resp = 1'b0;
    logic        exp_resp = 1'b0;
    logic [15:0] golden_sig = 16'h0000;
    logic        in_ready, busy, done, pass, trojan_flag;
    logic [1:0]  mismatch_cnt, first_mis_idx;
    logic [15:0] signature;

    logic        start_b = 1'b0;
    logic        in_valid_b = 1'b0;
    logic        N_b = 1'b0;
    logic        resp_b = 1'b0;
    logic        exp_b = 1'b0;
    logic [15:0] golden_b = 16'h0000;
    logic        in_ready_b, busy_b, done_b, pass_b, trojan_b;
    logic [0:0]  mismatch_cnt_b, first_mis_idx_b;
    logic [15:0] signature_b;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 CK = ~CK;

    trojan_resp_checker dut (
        .CK(CK), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .N(N), .resp(resp), .exp_resp(exp_resp),
        .golden_sig(golden_sig), .busy(busy), .done(done), .pass(pass),
        .trojan_flag(trojan_flag), .mismatch_cnt(mismatch_cnt),
        .first_mis_idx(first_mis_idx), .signature(signature)
    );

    trojan_resp_checker #(.VEC_COUNT(1), .MISR_SEED(16'h8000)) dut_b (
        .CK(CK), .reset(reset), .start(start_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .N(N_b), .resp(resp_b), .exp_resp(exp_b),
        .golden_sig(golden_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .trojan_flag(trojan_b), .mismatch_cnt(mismatch_cnt_b),
        .first_mis_idx(first_mis_idx_b), .signature(signature_b)
    );

    function automatic logic [15:0] model_step(logic [15:0] s, logic n, logic r);
        logic [15:0] t;
        t = {s[14:0], 1'b0};
        if (s[15]) t = t ^ 16'h1021;
        t[1] = t[1] ^ n;
        t[0] = t[0] ^ r;
        return t;
    endfunction

    // recs packs two records {rec1, rec0}, each {N, resp, exp_resp}.
    task automatic run_a(input string name, input logic [5:0] recs, input logic [15:0] golden,
                         input bit gaps, input bit noise);
        exp_t        e;
        logic [15:0] s;
        logic [2:0]  r;
        int          cnt, first, k;
        s = 16'h0000; cnt = 0; first = 0;
        for (int i = 0; i < 2; i++) begin
            r = recs[i*3 +: 3];
            s = model_step(s, r[2], r[1]);
            if (r[1] !== r[0]) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
        e.sig = s; e.cnt = 2'(cnt); e.first = 2'(first); e.pass = (s == golden) && (cnt == 0);
        exp_q.push_back(e);

        @(negedge CK); start = 1'b1; golden_sig = golden;
        @(negedge CK); start = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s run_entry: ready/busy/done got %b%b%b want 110", name, in_ready, busy, done);
        end
        checks++;
        if (signature !== 16'h0000 || mismatch_cnt !== 2'd0) begin
            errors++;
            $display("FAIL %s reseed: sig/cnt got %h/%0d want 0000/0", name, signature, mismatch_cnt);
        end

        for (int i = 0; i < 2; i++) begin
            if (gaps && i > 0) begin
                in_valid = 1'b0; start = noise;
                @(negedge CK); start = 1'b0;
            end
            in_valid = 1'b1; {N, resp, exp_resp} = recs[i*3 +: 3]; start = noise;
            @(negedge CK); start = 1'b0;
        end
        in_valid = 1'b0;

        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s check_cycle: busy/done/ready got %b%b%b want 100", name, busy, done, in_ready);
        end
        k = 0;
        while (done !== 1'b1 && k < 8) begin
            @(negedge CK); k++;
        end
        checks++;
        if (k != 1) begin
            errors++;
            $display("FAIL %s done_latency: got %0d cycles want 1", name, k);
        end

        e = exp_q.pop_front();
        checks++;
        if (signature !== e.sig) begin
            errors++;
            $display("FAIL %s signature: got %h want %h", name, signature, e.sig);
        end
        checks++;
        if (mismatch_cnt !== e.cnt || first_mis_idx !== e.first) begin
            errors++;
            $display("FAIL %s counts: cnt/first got %0d/%0d want %0d/%0d", name,
                     mismatch_cnt, first_mis_idx, e.cnt, e.first);
        end
        checks++;
        if (pass !== e.pass || trojan_flag !== ~e.pass) begin
            errors++;
            $display("FAIL %s verdict: pass/trojan got %b/%b want %b/%b", name,
                     pass, trojan_flag, e.pass, ~e.pass);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || trojan_flag !== 1'b0) begin
            errors++;
            $display("FAIL %s flags: ready/busy/done/pass/trojan got %b%b%b%b%b want 00000", name,
                     in_ready, busy, done, pass, trojan_flag);
        end
        checks++;
        if (mismatch_cnt !== 2'd0 || first_mis_idx !== 2'd0 || signature !== 16'h0000) begin
            errors++;
            $display("FAIL %s values: cnt/first/sig got %0d/%0d/%h want 0/0/0000", name,
                     mismatch_cnt, first_mis_idx, signature);
        end
    endtask

    task automatic test_reset();
        #1;
        check_reset_outputs("reset");
        checks++;
        if (signature_b !== 16'h0000 || busy_b !== 1'b0 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: sig/busy/done got %h/%b/%b want 0000/0/0", signature_b, busy_b, done_b);
        end
        @(negedge CK); reset = 1'b0;
        @(negedge CK);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy/ready got %b/%b want 0/0", busy, in_ready);
        end
    endtask

    task automatic test_clean_run();
        run_a("clean", {3'b111, 3'b000}, 16'h0003, 1'b0, 1'b0);
    endtask

    task automatic test_mismatch();
        run_a("mismatch", {3'b101, 3'b111}, 16'h0004, 1'b0, 1'b0);
    endtask

    task automatic test_feedback();
        logic [15:0] s;
        int          k;
        s = model_step(16'h8000, 1'b0, 1'b0);
        @(negedge CK); start_b = 1'b1; golden_b = 16'h1021;
        @(negedge CK); start_b = 1'b0;
        checks++;
        if (signature_b !== 16'h8000 || in_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL feedback_seed: sig/ready got %h/%b want 8000/1", signature_b, in_ready_b);
        end
        in_valid_b = 1'b1; {N_b, resp_b, exp_b} = 3'b000;
        @(negedge CK); in_valid_b = 1'b0;
        k = 0;
        while (done_b !== 1'b1 && k < 8) begin
            @(negedge CK); k++;
        end
        checks++;
        if (signature_b !== s || k != 1) begin
            errors++;
            $display("FAIL feedback_sig: sig/latency got %h/%0d want %h/1", signature_b, k, s);
        end
        checks++;
        if (pass_b !== 1'b1 || trojan_b !== 1'b0 || mismatch_cnt_b !== 1'b0) begin
            errors++;
            $display("FAIL feedback_verdict: pass/trojan/cnt got %b/%b/%0d want 1/0/0", pass_b, trojan_b, mismatch_cnt_b);
        end
    endtask

    task automatic test_valid_gaps();
        logic [15:0] held;
        run_a("gaps", {3'b011, 3'b100}, 16'h0005, 1'b1, 1'b1);
        held = signature;
        in_valid = 1'b1; {N, resp, exp_resp} = 3'b110;
        @(negedge CK);
        checks++;
        if (in_ready !== 1'b0 || signature !== held || done !== 1'b1 || mismatch_cnt !== 2'd0) begin
            errors++;
            $display("FAIL done_ignores_valid: ready/sig/done/cnt got %b/%h/%b/%0d want 0/%h/1/0",
                     in_ready, signature, done, mismatch_cnt, held);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        @(negedge CK); start = 1'b1; golden_sig = 16'h0003;
        @(negedge CK); start = 1'b0;
        in_valid = 1'b1; {N, resp, exp_resp} = 3'b101;
        @(negedge CK); in_valid = 1'b0;
        checks++;
        if (signature !== 16'h0002 || mismatch_cnt !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_run_state: sig/cnt/busy got %h/%0d/%b want 0002/1/1", signature, mismatch_cnt, busy);
        end
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge CK); reset = 1'b0;
        @(negedge CK);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy/ready/done got %b/%b/%b want 0/0/0", busy, in_ready, done);
        end
        run_a("post_reset", {3'b111, 3'b000}, 16'h0003, 1'b0, 1'b0);
    endtask

    task automatic test_restart();
        run_a("restart_a", {3'b110, 3'b011}, 16'h0001, 1'b0, 1'b0);
        run_a("restart_b", {3'b111, 3'b000}, 16'h0003, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_mismatch();
        test_feedback();
        test_valid_gaps();
        test_reset_mid_run();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
